// File: rtl/iop_pkg.sv
// Shared types and constants for the IOP pulse sequencer: state encoding,
// slot codes and default timing.
package iop_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEAD,
    P1,
    G1,
    P2,
    G2,
    P4,
    G4,
    DONE
  } state_t;

  localparam logic [1:0] SLOT_IDLE = 2'd0;
  localparam logic [1:0] SLOT_IOP1 = 2'd1;
  localparam logic [1:0] SLOT_IOP2 = 2'd2;
  localparam logic [1:0] SLOT_IOP4 = 2'd3;

  localparam int LEAD_CYC_DEF  = 2;
  localparam int PULSE_CYC_DEF = 10;
  localparam int GAP_CYC_DEF   = 5;

  // A pulse slot and the gap that follows it share one slot code.
  function automatic logic [1:0] slot_of(state_t s);
    case (s)
      P1, G1:  return SLOT_IOP1;
      P2, G2:  return SLOT_IOP2;
      P4, G4:  return SLOT_IOP4;
      default: return SLOT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/iop_slot_timer.sv
// 8-bit loadable down-counter that stops at zero; freeze holds the count.
module iop_slot_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       freeze,
  output logic       zero
);

  logic [7:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 8'd0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (!freeze && count_reg != 8'd0) begin
      count_reg <= count_reg - 8'd1;
    end
  end

  assign zero = (count_reg == 8'd0);

endmodule

// File: rtl/iop_sequencer.sv
// IOT pulse sequencer: LEAD, then IOP1/IOP2/IOP4 pulse slots each followed by
// a gap, then a one-cycle DONE. Outputs are registered from the next state.
module iop_sequencer
  import iop_pkg::*;
#(
  parameter int LEAD_CYC  = LEAD_CYC_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] ir,
  input  logic       hold,
  output logic       iop1_n,
  output logic       iop2_n,
  output logic       iop4_n,
  output logic       busy,
  output logic       done,
  output logic [1:0] slot
);

  localparam logic [7:0] LEAD_LOAD  = 8'(LEAD_CYC - 1);
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYC - 1);

  state_t     state_reg, state_next;
  logic [2:0] ir_reg;
  logic       load, zero, is_gap;
  logic [7:0] load_value;

  iop_slot_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_value(load_value),
    .freeze    (is_gap && hold),
    .zero      (zero)
  );

  // Hold only stalls gaps; LEAD and pulse states always run to completion.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    load_value = 8'd0;
    is_gap     = (state_reg == G1) || (state_reg == G2) || (state_reg == G4);
    case (state_reg)
      IDLE: if (start) begin
        state_next = LEAD;
        load       = 1'b1;
        load_value = LEAD_LOAD;
      end
      DONE: state_next = IDLE;
      default: if (zero && !(is_gap && hold)) begin
        load = 1'b1;
        case (state_reg)
          LEAD:    begin state_next = P1; load_value = PULSE_LOAD; end
          P1:      begin state_next = G1; load_value = GAP_LOAD;   end
          G1:      begin state_next = P2; load_value = PULSE_LOAD; end
          P2:      begin state_next = G2; load_value = GAP_LOAD;   end
          G2:      begin state_next = P4; load_value = PULSE_LOAD; end
          P4:      begin state_next = G4; load_value = GAP_LOAD;   end
          default: begin state_next = DONE; load = 1'b0;           end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      ir_reg    <= 3'b000;
      iop1_n    <= 1'b1;
      iop2_n    <= 1'b1;
      iop4_n    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      slot      <= SLOT_IDLE;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        ir_reg <= ir;
      end
      // LEAD is at least one cycle, so ir_reg is settled before P1 is entered.
      iop1_n <= !(state_next == P1 && ir_reg[0]);
      iop2_n <= !(state_next == P2 && ir_reg[1]);
      iop4_n <= !(state_next == P4 && ir_reg[2]);
      busy   <= (state_next != IDLE);
      done   <= (state_next == DONE);
      slot   <= slot_of(state_next);
    end
  end

endmodule

// File: tb/tb_iop_sequencer.sv
// Bench for iop_sequencer: directed sequences plus random traffic, all checked
// against a position-in-sequence reference model.
module tb_iop_sequencer;

  localparam int LEAD  = 2;
  localparam int PULSE = 10;
  localparam int GAP   = 5;
  localparam int TOTAL = LEAD + 3 * (PULSE + GAP) + 1;

  logic       clk = 1'b0;
  logic       reset, start, hold;
  logic [2:0] ir;
  logic       iop1_n, iop2_n, iop4_n, busy, done;
  logic [1:0] slot;

  int n_cmp = 0;
  int n_mis = 0;

  bit         m_active = 1'b0;
  int         m_pos    = 0;
  logic [2:0] m_cap    = 3'b000;

  always #5 clk = ~clk;

  iop_sequencer #(.LEAD_CYC(LEAD), .PULSE_CYC(PULSE), .GAP_CYC(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ir    (ir),
    .hold  (hold),
    .iop1_n(iop1_n),
    .iop2_n(iop2_n),
    .iop4_n(iop4_n),
    .busy  (busy),
    .done  (done),
    .slot  (slot)
  );

  // Position p counts 1..TOTAL within a sequence: LEAD, then three
  // (pulse + gap) blocks, then the DONE cycle.
  function automatic int pulse_idx(input int p);
    int r;
    r = p - LEAD;
    if (p >= TOTAL || r <= 0) return -1;
    if (((r - 1) % (PULSE + GAP)) < PULSE) return (r - 1) / (PULSE + GAP);
    return -1;
  endfunction

  function automatic bit in_gap(input int p);
    int r;
    r = p - LEAD;
    if (p >= TOTAL || r <= 0) return 1'b0;
    return ((r - 1) % (PULSE + GAP)) >= PULSE;
  endfunction

  function automatic int slot_exp(input bit act, input int p);
    if (!act || p <= LEAD || p >= TOTAL) return 0;
    return (p - LEAD - 1) / (PULSE + GAP) + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_cap    = 3'b000;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1;
        m_pos    = 1;
        m_cap    = ir;
      end
    end else if (m_pos == TOTAL) begin
      m_active = 1'b0;
      m_pos    = 0;
    end else if (!(in_gap(m_pos) && hold)) begin
      m_pos++;
    end
  endtask

  task automatic check_outputs();
    int pi;
    pi = m_active ? pulse_idx(m_pos) : -1;
    chk("busy", 32'(busy), 32'(m_active));
    chk("done", 32'(done), 32'(m_active && m_pos == TOTAL));
    chk("slot", 32'(slot), 32'(slot_exp(m_active, m_pos)));
    chk("iop1_n", 32'(iop1_n), 32'(!(pi == 0 && m_cap[0])));
    chk("iop2_n", 32'(iop2_n), 32'(!(pi == 1 && m_cap[1])));
    chk("iop4_n", 32'(iop4_n), 32'(!(pi == 2 && m_cap[2])));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // One sequence; stimulus windows are given in cycles after the start edge
  // (cycle 1 is the first busy cycle). -1 disables a window.
  task automatic run_seq(input logic [2:0] irv, input int hold_from, input int hold_to,
                         input int hold_pulse, input int restart_cyc, input int ir_chg_cyc,
                         input int reset_cyc, output int done_cyc, output int busy_cnt,
                         output int low1, output int low2, output int low4,
                         output int first1, output int first2, output int first4);
    int cyc;
    bit fin;
    done_cyc = 0; busy_cnt = 0; low1 = 0; low2 = 0; low4 = 0;
    first1 = 0; first2 = 0; first4 = 0;
    ir = irv; start = 1'b1; hold = 1'b0;
    step();
    start = 1'b0;
    cyc = 1;
    fin = 1'b0;
    while (!fin && cyc < 150) begin
      if (busy) busy_cnt++;
      if (!iop1_n) begin low1++; if (first1 == 0) first1 = cyc; end
      if (!iop2_n) begin low2++; if (first2 == 0) first2 = cyc; end
      if (!iop4_n) begin low4++; if (first4 == 0) first4 = cyc; end
      if (done) begin
        done_cyc = cyc;
        fin = 1'b1;
      end else if (!busy) begin
        fin = 1'b1;
      end
      if (!fin) begin
        hold  = (cyc >= hold_from && cyc <= hold_to) || cyc == hold_pulse;
        start = (cyc == restart_cyc);
        if (cyc == ir_chg_cyc) ir = 3'b000;
        reset = (cyc == reset_cyc);
        step();
        cyc++;
      end
    end
    if (!fin) chk("seq_timeout", 32'd0, 32'd1);
    hold = 1'b0; start = 1'b0; reset = 1'b0;
    step();
  endtask

  initial begin
    int d, b, l1, l2, l4, f1, f2, f4;
    int d1, d2, r2;
    bit prev_busy;

    reset = 1'b1; start = 1'b1; hold = 1'b1; ir = 3'b111;
    step();
    step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_iops", 32'({iop1_n, iop2_n, iop4_n}), 32'd7);
    reset = 1'b0; start = 1'b0; hold = 1'b0;
    step();

    run_seq(3'b111, -1, -1, -1, -1, -1, -1, d, b, l1, l2, l4, f1, f2, f4);
    $display("seq ir=111: done@%0d busy=%0d iop1 %0d@%0d iop2 %0d@%0d iop4 %0d@%0d",
             d, b, l1, f1, l2, f2, l4, f4);
    chk("all_done_cyc", 32'(d), 32'd48);
    chk("all_busy_cnt", 32'(b), 32'd48);
    chk("all_iop1_first", 32'(f1), 32'd3);
    chk("all_iop2_first", 32'(f2), 32'd18);
    chk("all_iop4_first", 32'(f4), 32'd33);
    chk("all_widths", 32'(l1 + l2 + l4), 32'd30);

    run_seq(3'b010, -1, -1, -1, -1, -1, -1, d, b, l1, l2, l4, f1, f2, f4);
    $display("seq ir=010: done@%0d iop1 %0d iop2 %0d iop4 %0d", d, l1, l2, l4);
    chk("ir010_done_cyc", 32'(d), 32'd48);
    chk("ir010_iop2_w", 32'(l2), 32'd10);
    chk("ir010_others", 32'(l1 + l4), 32'd0);

    run_seq(3'b111, 14, 20, 28, -1, -1, -1, d, b, l1, l2, l4, f1, f2, f4);
    $display("seq hold: done@%0d busy=%0d iop2 %0d@%0d", d, b, l2, f2);
    chk("hold_done_cyc", 32'(d), 32'd55);
    chk("hold_busy_cnt", 32'(b), 32'd55);
    chk("hold_p2_first", 32'(f2), 32'd25);
    chk("hold_p2_width", 32'(l2), 32'd10);

    run_seq(3'b101, -1, -1, -1, 5, 6, -1, d, b, l1, l2, l4, f1, f2, f4);
    $display("seq restart: done@%0d iop1 %0d iop2 %0d iop4 %0d@%0d", d, l1, l2, l4, f4);
    chk("restart_done_cyc", 32'(d), 32'd48);
    chk("restart_iop1_w", 32'(l1), 32'd10);
    chk("restart_iop2_w", 32'(l2), 32'd0);
    chk("restart_iop4_w", 32'(l4), 32'd10);

    run_seq(3'b100, -1, -1, -1, -1, -1, 36, d, b, l1, l2, l4, f1, f2, f4);
    $display("seq reset in P4: done@%0d busy=%0d iop4 %0d", d, b, l4);
    chk("rst_no_done", 32'(d), 32'd0);
    chk("rst_iop4_w", 32'(l4), 32'd4);
    chk("rst_busy_cnt", 32'(b), 32'd36);

    run_seq(3'b100, -1, -1, -1, -1, -1, -1, d, b, l1, l2, l4, f1, f2, f4);
    $display("seq after reset: done@%0d iop4 %0d@%0d", d, l4, f4);
    chk("post_rst_done", 32'(d), 32'd48);
    chk("post_rst_iop4", 32'(l4), 32'd10);

    ir = 3'b011; start = 1'b1;
    d1 = 0; d2 = 0; r2 = 0; prev_busy = 1'b0;
    for (int k = 1; k <= 160 && d2 == 0; k++) begin
      step();
      if (busy && !prev_busy && d1 != 0) r2 = k;
      if (done) begin
        if (d1 == 0) d1 = k;
        else d2 = k;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    step();
    $display("seq back-to-back: done@%0d restart@%0d done@%0d", d1, r2, d2);
    chk("b2b_idle_gap", 32'(r2 - d1), 32'd2);
    chk("b2b_period", 32'(d2 - d1), 32'(TOTAL + 1));

    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      ir    = 3'($urandom_range(0, 7));
      step();
    end
    reset = 1'b0; start = 1'b0; hold = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/iop_sequencer.md
IOP_SEQUENCER -- requirements
Module: iop_sequencer

Interface
REQ-001 The parameter LEAD_CYC SHALL default to 2 and set the cycles from start to slot 1.
REQ-002 The parameter PULSE_CYC SHALL default to 10 and set the width in cycles of each IOP pulse slot; the legal range is 1..255.
REQ-003 The parameter GAP_CYC SHALL default to 5 and set the gap in cycles after each pulse slot; the legal range is 1..255, and LEAD_CYC has the same range.
REQ-004 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state changes on its rising edge.
REQ-005 The port reset SHALL be an input, 1 bit wide, with synchronous, active-high reset.
REQ-006 The port start SHALL be an input, 1 bit wide: an IOT execute request, sampled only in IDLE.
REQ-007 The port ir SHALL be an input, 3 bits wide: IR9..IR11, where ir[0]=IR11 enables IOP1, ir[1]=IR10 enables IOP2, and ir[2]=IR9 enables IOP4.
REQ-008 The port hold SHALL be an input, 1 bit wide: a slow-device pause that freezes the sequence in gap states only.
REQ-009 The ports iop1_n, iop2_n and iop4_n SHALL be outputs, 1 bit each: registered, active-low bus pulses in power-amplifier drive polarity.
REQ-010 The port busy SHALL be an output, 1 bit wide, high from acceptance of start until the sequence ends.
REQ-011 The port done SHALL be an output, 1 bit wide: a one-cycle pulse at sequence completion.
REQ-012 The port slot SHALL be an output, 2 bits wide: 0 = idle/lead, 1/2/3 = IOP1/IOP2/IOP4 slot, including its gap.

Function
REQ-013 The state machine SHALL have the states IDLE, LEAD, P1, G1, P2, G2, P4, G4 and DONE.
REQ-014 In IDLE with start=1 at edge k, the block SHALL capture ir into an internal register, enter LEAD, and show busy=1 after edge k.
REQ-015 Once started, each timed state SHALL last exactly its parameter count: LEAD_CYC for LEAD, PULSE_CYC for P*, and GAP_CYC for G*.
REQ-016 The state order SHALL be LEAD, P1, G1, P2, G2, P4, G4, DONE, then IDLE.
REQ-017 Pulse slots SHALL always elapse; the iopX_n output goes low for all PULSE_CYC cycles of its P-state only if the captured enable bit is set.
REQ-018 All iopX_n outputs SHALL be high in every state other than their own P-state.
REQ-019 DONE SHALL last one cycle with done=1; busy SHALL be 0 from the cycle after DONE onward.
REQ-020 With hold=1 in a G-state, or on a G-state's final cycle, the counter SHALL freeze and the state SHALL not advance until hold=0.
REQ-021 hold SHALL be ignored in LEAD and P-states; pulse width is never stretched.
REQ-022 A start asserted while busy=1 SHALL be ignored and not queued.
REQ-023 Changes to ir after capture SHALL have no effect on the current sequence.
REQ-024 A start asserted in the same cycle as DONE SHALL be ignored; a new sequence can be accepted in IDLE one cycle after DONE at the earliest.
REQ-025 The sequence length with hold=0 SHALL be LEAD_CYC + 3*(PULSE_CYC+GAP_CYC) + 1 cycles of busy=1, DONE included.
REQ-026 The timing counter SHALL be 8 bits wide, load parameter minus 1 on state entry, and advance state at 0; it never wraps.
REQ-027 With ir=000, the full timing SHALL still run with no pulses.

Reset
REQ-028 reset=1 at an edge SHALL force the following: state=IDLE, iop1_n=iop2_n=iop4_n=1, busy=0, done=0, slot=0, counter=0, captured ir=0.
REQ-029 Reset asserted mid-pulse SHALL deassert the pulse (output 1) after that same edge, with no done pulse.
REQ-030 reset SHALL take priority over start and hold in the same cycle.

Structure
REQ-031 The package iop_pkg SHALL hold the state enumeration, the slot encoding constants, and the default values of LEAD_CYC, PULSE_CYC and GAP_CYC.
REQ-032 The 8-bit loadable down-counter with freeze input SHALL be a single sub-module named iop_slot_timer; the FSM and output registers stay in iop_sequencer.

Verification
REQ-033 The bench SHALL cover this case with default parameters: ir=111, start for one cycle, giving busy=1 for 48 cycles; iop1_n low cycles 3-12, iop2_n low cycles 18-27, and iop4_n low cycles 33-42 after start; done at cycle 48.
REQ-034 The bench SHALL cover ir=010: only iop2_n pulses (10 cycles low), iop1_n/iop4_n stay 1, and done still at cycle 48.
REQ-035 The bench SHALL cover hold=1 for 7 cycles starting mid-G1, plus hold=1 pulsed during P2: G1 extended by 7 cycles, P2 width still 10, and done at cycle 55.
REQ-036 The bench SHALL cover start re-asserted during P1 with ir changed to 000 mid-sequence: no restart, and the original captured pulses complete unchanged.
REQ-037 The bench SHALL cover reset asserted during P4 with ir=100: iop4_n=1 and busy=0 after that edge, no done, and the next start is accepted normally.
REQ-038 The bench SHALL cover start held high continuously: back-to-back sequences with exactly one IDLE cycle between DONE and the next LEAD.
